// File: rtl/divider.sv
// Iterative signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, then sign correction. Fixed latency of
// NUM_IN_BITS+2 cycles from the accepting edge to the done pulse.
// Optional feature macro: DIVIDER_SAT_EN (saturate quotient on divide-by-zero
// and overflow instead of returning the raw/wrapped result).
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module divider #(
    parameter int NUM_IN_BITS = `BYTE_BITS,
    parameter int DIV_BITS    = `BYTE_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          trigger,
    input  logic signed [NUM_IN_BITS-1:0] num_in,
    input  logic signed [DIV_BITS-1:0]    div,
    output logic                          busy,
    output logic                          done,
    output logic signed [NUM_IN_BITS-1:0] quot,
    output logic signed [DIV_BITS-1:0]    rem,
    output logic                          div_by_zero,
    output logic                          ovf
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic signed [NUM_IN_BITS-1:0] NUM_MIN  = {1'b1, {(NUM_IN_BITS-1){1'b0}}};
    localparam logic signed [DIV_BITS-1:0]    DIV_NEG1 = {DIV_BITS{1'b1}};

    state_t state, state_nxt;
    logic   load, step, fix, last;

    logic [NUM_IN_BITS-1:0] cnt;

    logic signed [NUM_IN_BITS-1:0] num_p0;
    logic signed [DIV_BITS-1:0]    div_p0;
    logic        [DIV_BITS-1:0]    divmag_p0;
    logic        [NUM_IN_BITS-1:0] shreg_p1;  // dividend bits shift out, quotient bits shift in
    logic        [DIV_BITS-1:0]    part_p1;

    logic [DIV_BITS:0]    part_sh;
    logic [DIV_BITS:0]    diff;
    logic                 ge;

    logic signed [NUM_IN_BITS-1:0] quot_fix;
    logic signed [DIV_BITS-1:0]    rem_fix;
    logic                          dz_fix;
    logic                          ovf_fix;

    function automatic logic [NUM_IN_BITS-1:0] abs_num(input logic signed [NUM_IN_BITS-1:0] x);
        logic [NUM_IN_BITS-1:0] u;
        u = x;
        return x[NUM_IN_BITS-1] ? (~u + NUM_IN_BITS'(1)) : u;
    endfunction

    function automatic logic [DIV_BITS-1:0] abs_div(input logic signed [DIV_BITS-1:0] x);
        logic [DIV_BITS-1:0] u;
        u = x;
        return x[DIV_BITS-1] ? (~u + DIV_BITS'(1)) : u;
    endfunction

    // Sign-extend or truncate the dividend into the remainder width.
    function automatic logic signed [DIV_BITS-1:0] sext_rem(input logic signed [NUM_IN_BITS-1:0] x);
        logic [NUM_IN_BITS+DIV_BITS-1:0] w;
        w = {{DIV_BITS{x[NUM_IN_BITS-1]}}, x};
        return w[DIV_BITS-1:0];
    endfunction

`ifdef DIVIDER_SAT_EN
    // Most-positive or most-negative quotient depending on result sign.
    function automatic logic signed [NUM_IN_BITS-1:0] sat_quot(input logic neg);
        return neg ? {1'b1, {(NUM_IN_BITS-1){1'b0}}} : {1'b0, {(NUM_IN_BITS-1){1'b1}}};
    endfunction
`endif

    assign busy = (state != IDLE);
    assign last = (cnt == NUM_IN_BITS'(NUM_IN_BITS-1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) state_nxt = FIX;
            end
            FIX: begin
                fix       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step; the borrow of the trial subtraction is the compare.
    always_comb begin
        part_sh = {part_p1, shreg_p1[NUM_IN_BITS-1]};
        diff    = part_sh - {1'b0, divmag_p0};
        ge      = ~diff[DIV_BITS];
    end

    // Operand capture and iteration datapath (not reset).
    always_ff @(posedge clk) begin
        if (load) begin
            num_p0    <= num_in;
            div_p0    <= div;
            divmag_p0 <= abs_div(div);
            shreg_p1  <= abs_num(num_in);
            part_p1   <= '0;
        end else if (step) begin
            part_p1  <= ge ? diff[DIV_BITS-1:0] : part_sh[DIV_BITS-1:0];
            shreg_p1 <= {shreg_p1[NUM_IN_BITS-2:0], ge};
        end
    end

    // Sign correction and special-case results.
    always_comb begin
        quot_fix = (num_p0[NUM_IN_BITS-1] ^ div_p0[DIV_BITS-1]) ? (~shreg_p1 + NUM_IN_BITS'(1)) : shreg_p1;
        rem_fix  = num_p0[NUM_IN_BITS-1] ? (~part_p1 + DIV_BITS'(1)) : part_p1;
        dz_fix   = (div_p0 == '0);
        ovf_fix  = (num_p0 == NUM_MIN) && (div_p0 == DIV_NEG1);
        if (dz_fix) begin
`ifdef DIVIDER_SAT_EN
            quot_fix = sat_quot(num_p0[NUM_IN_BITS-1]);
            rem_fix  = '0;
`else
            quot_fix = '0;
            rem_fix  = sext_rem(num_p0);
`endif
        end else if (ovf_fix) begin
`ifdef DIVIDER_SAT_EN
            quot_fix = sat_quot(1'b0);
`else
            quot_fix = NUM_MIN;
`endif
            rem_fix  = '0;
        end
    end

    // Iteration counter, result registers and done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= '0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            done <= fix;
            if (load)      cnt <= '0;
            else if (step) cnt <= cnt + NUM_IN_BITS'(1);
            if (fix) begin
                quot        <= quot_fix;
                rem         <= rem_fix;
                div_by_zero <= dz_fix;
                ovf         <= ovf_fix;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider with default 8-bit widths.
module tb_divider;

    logic              clk = 1'b0;
    logic              reset;
    logic              trigger;
    logic signed [7:0] num_in;
    logic signed [7:0] div;
    logic              busy;
    logic              done;
    logic signed [7:0] quot;
    logic signed [7:0] rem;
    logic              div_by_zero;
    logic              ovf;

    int tests_run = 0;
    int failed    = 0;

    divider dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .num_in      (num_in),
        .div         (div),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one division from an idle cycle and wait (bounded) for done.
    task automatic run_div(input int n, input int d, output int lat, output int bcnt,
                           output int q, output int r, output logic dz, output logic ov);
        trigger = 1'b1;
        num_in  = 8'(n);
        div     = 8'(d);
        @(posedge clk); #1;
        trigger = 1'b0;
        num_in  = 8'sh5A;
        div     = 8'sh33;
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        q  = int'(quot);
        r  = int'(rem);
        dz = div_by_zero;
        ov = ovf;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        trigger = 1'b0;
        num_in  = '0;
        div     = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (quot !== 8'sd0) begin failed++; $display("FAIL reset_quot: got %0d expected 0", quot); end
        tests_run++; if (rem !== 8'sd0) begin failed++; $display("FAIL reset_rem: got %0d expected 0", rem); end
        tests_run++; if ({div_by_zero, ovf} !== 2'b00) begin failed++; $display("FAIL reset_flags: got %b expected 00", {div_by_zero, ovf}); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bcnt, q, r;
        logic dz, ov;
        run_div(100, 7, lat, bcnt, q, r, dz, ov);
        tests_run++; if (lat != 10) begin failed++; $display("FAIL basic_latency: got %0d expected 10", lat); end
        tests_run++; if (bcnt != 9) begin failed++; $display("FAIL basic_busy_cycles: got %0d expected 9", bcnt); end
        tests_run++; if (q != 14) begin failed++; $display("FAIL basic_quot: got %0d expected 14", q); end
        tests_run++; if (r != 2) begin failed++; $display("FAIL basic_rem: got %0d expected 2", r); end
        tests_run++; if ({dz, ov} !== 2'b00) begin failed++; $display("FAIL basic_flags: got %b expected 00", {dz, ov}); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
        @(posedge clk); #1;
        tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_signs();
        int tn[4] = '{-100, 100, -100, -128};
        int td[4] = '{7, -7, -7, 3};
        int eq[4] = '{-14, -14, 14, -42};
        int er[4] = '{-2, 2, -2, -2};
        int lat, bcnt, q, r;
        logic dz, ov;
        for (int i = 0; i < 4; i++) begin
            run_div(tn[i], td[i], lat, bcnt, q, r, dz, ov);
            tests_run++; if (q != eq[i]) begin failed++; $display("FAIL signs_quot[%0d]: got %0d expected %0d", i, q, eq[i]); end
            tests_run++; if (r != er[i]) begin failed++; $display("FAIL signs_rem[%0d]: got %0d expected %0d", i, r, er[i]); end
            tests_run++; if (lat != 10) begin failed++; $display("FAIL signs_latency[%0d]: got %0d expected 10", i, lat); end
        end
    endtask

    task automatic test_overflow();
        int lat, bcnt, q, r, eq;
        logic dz, ov;
`ifdef DIVIDER_SAT_EN
        eq = 127;
`else
        eq = -128;
`endif
        run_div(-128, -1, lat, bcnt, q, r, dz, ov);
        tests_run++; if (ov !== 1'b1) begin failed++; $display("FAIL ovf_flag: got %b expected 1", ov); end
        tests_run++; if (dz !== 1'b0) begin failed++; $display("FAIL ovf_dz_flag: got %b expected 0", dz); end
        tests_run++; if (q != eq) begin failed++; $display("FAIL ovf_quot: got %0d expected %0d", q, eq); end
        tests_run++; if (r != 0) begin failed++; $display("FAIL ovf_rem: got %0d expected 0", r); end
        tests_run++; if (lat != 10) begin failed++; $display("FAIL ovf_latency: got %0d expected 10", lat); end
    endtask

    task automatic test_div_zero();
        int tn[2] = '{5, -5};
`ifdef DIVIDER_SAT_EN
        int eq[2] = '{127, -128};
        int er[2] = '{0, 0};
`else
        int eq[2] = '{0, 0};
        int er[2] = '{5, -5};
`endif
        int lat, bcnt, q, r;
        logic dz, ov;
        for (int i = 0; i < 2; i++) begin
            run_div(tn[i], 0, lat, bcnt, q, r, dz, ov);
            tests_run++; if (dz !== 1'b1) begin failed++; $display("FAIL dz_flag[%0d]: got %b expected 1", i, dz); end
            tests_run++; if (ov !== 1'b0) begin failed++; $display("FAIL dz_ovf_flag[%0d]: got %b expected 0", i, ov); end
            tests_run++; if (q != eq[i]) begin failed++; $display("FAIL dz_quot[%0d]: got %0d expected %0d", i, q, eq[i]); end
            tests_run++; if (r != er[i]) begin failed++; $display("FAIL dz_rem[%0d]: got %0d expected %0d", i, r, er[i]); end
            tests_run++; if (lat != 10) begin failed++; $display("FAIL dz_latency[%0d]: got %0d expected 10", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        trigger = 1'b1;
        num_in  = 8'sd20;
        div     = 8'sd3;
        @(posedge clk); #1;
        // Trigger stays high through CALC with different operands.
        num_in = 8'sd9;
        div    = -8'sd2;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++; if (lat != 10) begin failed++; $display("FAIL b2b_latency_first: got %0d expected 10", lat); end
        tests_run++; if (quot !== 8'sd6) begin failed++; $display("FAIL b2b_quot_first: got %0d expected 6", quot); end
        tests_run++; if (rem !== 8'sd2) begin failed++; $display("FAIL b2b_rem_first: got %0d expected 2", rem); end
        @(posedge clk); #1;
        trigger = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++; if (lat != 10) begin failed++; $display("FAIL b2b_latency_second: got %0d expected 10", lat); end
        tests_run++; if (quot !== -8'sd4) begin failed++; $display("FAIL b2b_quot_second: got %0d expected -4", quot); end
        tests_run++; if (rem !== 8'sd1) begin failed++; $display("FAIL b2b_rem_second: got %0d expected 1", rem); end
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL b2b_no_third: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, q, r, dones;
        logic dz, ov;
        trigger = 1'b1;
        num_in  = 8'sd100;
        div     = 8'sd7;
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        tests_run++; if (quot !== 8'sd0) begin failed++; $display("FAIL rstmid_quot: got %0d expected 0", quot); end
        tests_run++; if (rem !== 8'sd0) begin failed++; $display("FAIL rstmid_rem: got %0d expected 0", rem); end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        tests_run++; if (dones != 0) begin failed++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dones); end
        run_div(100, 7, lat, bcnt, q, r, dz, ov);
        tests_run++; if (lat != 10) begin failed++; $display("FAIL rstmid_after_latency: got %0d expected 10", lat); end
        tests_run++; if (q != 14 || r != 2) begin failed++; $display("FAIL rstmid_after_result: got %0d/%0d expected 14/2", q, r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
